// File: rtl/msg_deframer.sv
// Purpose: assemble fixed-length header-checked messages from a byte stream into a wide word.
// Latency: 1 cycle from the last accepted byte to msg_valid when the output register is free.
// Backpressure: byte_ready drops only while a complete frame waits for the occupied output register.
module msg_deframer #(
  parameter int          MSG_BYTES = 21,
  parameter logic [23:0] HDR       = 24'h000000,
  parameter int          TIMEOUT   = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic [8*MSG_BYTES-1:0] msg,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic                   frame_err,
  output logic [7:0]             drop_count
);

  localparam int MW = 8 * MSG_BYTES;
  localparam int IW = $clog2(MSG_BYTES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(MSG_BYTES - 1);
  localparam logic [IW-1:0] HDR_LAST = IW'(2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_HDR, S_BODY, S_FULL} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_idle;
  logic [MW-1:0] r_asm;
  logic [MW-1:0] r_msg;
  logic          r_msg_vld;
  logic          r_ferr;
  logic [7:0]    r_drop;

  logic          w_byte_rdy;
  logic          w_acc;
  logic [7:0]    w_hdr_byte;
  logic          w_hdr_ok;
  logic          w_mismatch;
  logic          w_timeout;
  logic          w_last;
  logic          w_out_free;
  logic          w_load_direct;
  logic          w_load_full;
  logic          w_load;
  logic          w_drop;
  logic [MW-1:0] w_shifted;
  logic [MW-1:0] w_load_dat;

  assign w_byte_rdy    = (r_state != S_FULL);
  assign w_acc         = byte_valid && w_byte_rdy;
  assign w_out_free    = !r_msg_vld || msg_ready;
  assign w_hdr_ok      = (byte_in == w_hdr_byte);
  assign w_mismatch    = (r_state == S_HDR) && w_acc && !w_hdr_ok;
  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_timeout     = (r_state != S_FULL) && (r_idx != '0) && !w_acc && (r_idle == TO_LAST);
  assign w_last        = (r_state == S_BODY) && w_acc && (r_idx == LAST_IDX);
  assign w_load_direct = w_last && w_out_free;
  assign w_load_full   = (r_state == S_FULL) && r_msg_vld && msg_ready;
  assign w_load        = w_load_direct || w_load_full;
  assign w_drop        = w_mismatch || w_timeout;
  assign w_shifted     = {r_asm[MW-9:0], byte_in};
  assign w_load_dat    = (r_state == S_FULL) ? r_asm : w_shifted;

  assign byte_ready = w_byte_rdy;
  assign msg        = r_msg;
  assign msg_valid  = r_msg_vld;
  assign frame_err  = r_ferr;
  assign drop_count = r_drop;

  // Select the header byte expected at the current index.
  always_comb begin
    w_hdr_byte = HDR[7:0];
    if (r_idx == '0)
      w_hdr_byte = HDR[23:16];
    else if (r_idx == IW'(1))
      w_hdr_byte = HDR[15:8];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HDR;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state: header check, body collection, and waiting on a full output register.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_acc && w_hdr_ok && (r_idx == HDR_LAST)) w_state_nxt = S_BODY;
      end
      S_BODY: begin
        if (w_timeout)   w_state_nxt = S_HDR;
        else if (w_last) w_state_nxt = w_out_free ? S_HDR : S_FULL;
      end
      S_FULL: begin
        if (r_msg_vld && msg_ready) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Byte index, idle counter and assembly shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx  <= '0;
      r_idle <= '0;
      r_asm  <= '0;
    end else begin
      if (w_drop || w_load) r_idx <= '0;
      else if (w_acc)       r_idx <= r_idx + IW'(1);

      // Idle counter only runs mid-frame and is frozen while a frame waits in FULL.
      if ((r_idx == '0) || w_acc || w_timeout) r_idle <= '0;
      else if (r_state != S_FULL)              r_idle <= r_idle + CW'(1);

      // A mismatching header byte is dropped, never shifted in.
      if (w_acc && !w_mismatch) r_asm <= w_shifted;
    end
  end

  // One-entry output register plus error pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msg     <= '0;
      r_msg_vld <= 1'b0;
      r_ferr    <= 1'b0;
      r_drop    <= '0;
    end else begin
      if (w_load) begin
        r_msg     <= w_load_dat;
        r_msg_vld <= 1'b1;
      end else if (r_msg_vld && msg_ready) begin
        r_msg_vld <= 1'b0;
      end
      r_ferr <= w_drop;
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

endmodule

// File: tb/tb_msg_deframer.sv
// Purpose: scoreboard-based bench for msg_deframer (framing, header errors, backpressure, timeout, reset, saturation).
// Latency: expected messages are queued at stimulus time and compared on each output handshake.
// Backpressure: byte sends wait on byte_ready with a bounded cycle budget.
module tb_msg_deframer;

  localparam int MB = 21;
  localparam int TO = 1000;
  localparam int MW = 8 * MB;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic [7:0]    byte_in    = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [MW-1:0] msg;
  logic          msg_valid;
  logic          msg_ready  = 1'b0;
  logic          frame_err;
  logic [7:0]    drop_count;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_ferr  = 0;
  logic [MW-1:0] exp_q[$];
  logic          hold     = 1'b0;
  logic [MW-1:0] prev_msg = '0;

  msg_deframer #(.MSG_BYTES(MB), .HDR(24'h000000), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .msg        (msg),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .frame_err  (frame_err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] frame_word(input logic [31:0] price);
    return {24'd0, 32'd1, price, 32'd0, 8'd1, 32'd1, 8'd0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    while (!byte_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!byte_ready) check("byte_ready_wait", MW'(byte_ready), MW'(1));
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input logic [MW-1:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(w[MW-1-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [MW-1:0] w);
    exp_q.push_back(w);
    send_range(w, 0, MB - 1);
  endtask

  // Output monitor: scoreboard pop on handshake, hold-stability, frame_err pulse count.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (frame_err) n_ferr++;
        if (hold && msg_valid) check("msg_stable", msg, prev_msg);
        if (msg_valid && msg_ready) begin
          check("msg_pending", MW'(exp_q.size() != 0), MW'(1));
          if (exp_q.size() != 0) check("msg", msg, exp_q.pop_front());
        end
        hold     = msg_valid && !msg_ready;
        prev_msg = msg;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d0;
    int         f0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_msg_valid", MW'(msg_valid), MW'(0));
    check("rst_msg", msg, '0);
    check("rst_byte_ready", MW'(byte_ready), MW'(1));
    check("rst_drop", MW'(drop_count), MW'(0));
    check("rst_ferr", MW'(frame_err), MW'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, consumer always ready
    msg_ready = 1'b1;
    f0 = n_ferr;
    send_frame(frame_word(32'd104));
    check("basic_latency_vld", MW'(msg_valid), MW'(1));
    check("basic_msg", msg, {24'd0, 32'd1, 32'd104, 32'd0, 8'd1, 32'd1, 8'd0});
    @(posedge clk);
    #1;
    check("basic_no_ferr", MW'(n_ferr - f0), MW'(0));

    // Header mismatch at second header byte, then a good frame
    f0 = n_ferr;
    send_byte(8'h00);
    send_byte(8'h7F);
    send_frame(frame_word(32'd55));
    @(posedge clk);
    #1;
    check("hdr_ferr_pulses", MW'(n_ferr - f0), MW'(1));
    check("hdr_drop", MW'(drop_count), MW'(1));

    // Backpressure: two frames while consumer stalls
    msg_ready = 1'b0;
    send_frame(frame_word(32'd96));
    send_frame(frame_word(32'd103));
    @(negedge clk);
    check("bp_byte_ready_low", MW'(byte_ready), MW'(0));
    check("bp_vld", MW'(msg_valid), MW'(1));
    check("bp_held_first", msg, frame_word(32'd96));
    @(posedge clk);
    #1;
    msg_ready = 1'b1;
    @(posedge clk);
    #1;
    msg_ready = 1'b0;
    check("bp_b2b_vld", MW'(msg_valid), MW'(1));
    check("bp_second", msg, frame_word(32'd103));
    check("bp_byte_ready_back", MW'(byte_ready), MW'(1));
    msg_ready = 1'b1;
    @(posedge clk);
    #1;

    // Timeout: 10 bytes then TO idle cycles
    d0 = drop_count;
    send_range(frame_word(32'd7), 0, 9);
    repeat (TO) @(posedge clk);
    #1;
    check("to_ferr", MW'(frame_err), MW'(1));
    check("to_drop", MW'(drop_count), MW'(d0 + 8'd1));
    send_frame(frame_word(32'd33));

    // Byte arriving on the expiry cycle: no timeout
    d0 = drop_count;
    f0 = n_ferr;
    exp_q.push_back(frame_word(32'd44));
    send_range(frame_word(32'd44), 0, 9);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_range(frame_word(32'd44), 10, MB - 1);
    @(posedge clk);
    #1;
    check("to_edge_no_ferr", MW'(n_ferr - f0), MW'(0));
    check("to_edge_drop", MW'(drop_count), MW'(d0));

    // Asynchronous reset mid-frame
    send_range(frame_word(32'd9), 0, 14);
    #3;
    rst = 1'b0;
    #1;
    check("arst_msg_valid", MW'(msg_valid), MW'(0));
    check("arst_msg", msg, '0);
    check("arst_drop", MW'(drop_count), MW'(0));
    check("arst_ferr", MW'(frame_err), MW'(0));
    check("arst_byte_ready", MW'(byte_ready), MW'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_frame(frame_word(32'd77));
    @(posedge clk);
    #1;

    // Drop counter saturation
    for (int i = 0; i < 254; i++) send_byte(8'hFF);
    check("sat_254", MW'(drop_count), MW'(254));
    send_byte(8'hFF);
    check("sat_255", MW'(drop_count), MW'(255));
    for (int i = 0; i < 5; i++) send_byte(8'hFF);
    check("sat_hold", MW'(drop_count), MW'(255));

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", MW'(exp_q.size()), MW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msg_deframer.md
Name: msg_deframer

Overview:
- Receives a byte stream from the host link (UART receiver output) and assembles fixed 21-byte order messages into the 168-bit message word consumed by the sequencer/processor path.
- Replaces the hardcoded message buffer and push-button stepping as the message source.
- Checks the 3-byte header and discards malformed or stalled frames.
- Presents each completed message on a valid/ready handshake backed by a one-entry output register.

Parameters:
- MSG_BYTES, 21, bytes per message; message width is 8*MSG_BYTES = 168.
- HDR, 24'h000000, required value of the first three bytes (msg[167:144]).
- TIMEOUT, 1000, idle cycles allowed between bytes of a partially received frame before it is discarded.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  deframer accepts byte_in this cycle. A transfer occurs when byte_valid && byte_ready.
- msg  out  168  assembled message. The first byte received is msg[167:160]; the last is msg[7:0].
- msg_valid  out  1  msg holds an unconsumed message.
- msg_ready  in  1  consumer takes msg this cycle when msg_valid && msg_ready.
- frame_err  out  1  one-cycle pulse on each discarded frame.
- drop_count  out  8  number of discarded frames, saturating at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - msg=0, msg_valid=0, frame_err=0, drop_count=0, byte_ready=1.
  - Byte index=0, idle counter=0, state=HDR.
  - Reset asserted mid-frame or while holding a message discards everything.
- State HDR (index 0..2):
  - Each accepted byte is compared with HDR byte [23-8*index -: 8].
  - Match: shift the byte into the assembly register, index+1. When index reaches 3, go to BODY.
  - Mismatch: drop the byte, index=0, frame_err pulses on the next cycle, drop_count increments. The mismatching byte is not re-examined as a new header start.
- State BODY (index 3..20): each accepted byte is shifted in, index+1.
- Completion, on the cycle byte index 20 is accepted:
  - If the output register is free next cycle (msg_valid==0, or msg_valid && msg_ready this cycle): msg loads the full assembly word on the next edge, msg_valid=1, index=0, state=HDR. Latency is 1 cycle from the last byte to msg_valid.
  - Otherwise go to FULL with the complete word held in the assembly register.
- State FULL:
  - byte_ready=0; the idle counter is frozen.
  - When msg_valid && msg_ready: msg loads the assembly word on the next edge and msg_valid stays 1 (back-to-back), index=0, state=HDR.
- byte_ready is 1 in HDR and BODY and 0 only in FULL. Back-to-back bytes every cycle are sustained.
- msg_valid and msg:
  - Set/loaded as described above.
  - Cleared only when msg_valid && msg_ready with no simultaneous load.
  - msg is stable while msg_valid=1 and msg_ready=0.
- Timeout:
  - While index!=0 and state!=FULL, the idle counter increments on every cycle without an accepted byte and clears on an accepted byte.
  - At counter==TIMEOUT-1 with no byte accepted: discard the partial frame, index=0, state=HDR, frame_err pulse, drop_count+1.
  - A byte accepted on the same cycle takes priority; no timeout occurs.
  - The counter is held at 0 when index==0.
- drop_count saturates at 255. Header mismatch and timeout each count as one drop.
- A pending msg in the output register is never affected by frame errors.

Test Plan:
- Basic frame: send 00 00 00 00 00 00 01 00 00 00 68 00 00 00 00 01 00 00 00 01 00 on consecutive cycles with msg_ready=1.
  - msg_valid=1 one cycle after the last byte.
  - msg = {24'd0,32'd1,32'd104,32'd0,8'd1,32'd1,8'd0}.
  - frame_err never asserted.
- Header error: send 00 7F, then a valid 21-byte frame.
  - One frame_err pulse, drop_count=1.
  - The subsequent frame is assembled correctly.
- Backpressure: msg_ready=0, send two valid frames (price 96 then 103).
  - First msg held stable.
  - byte_ready=0 after the 21st byte of frame 2.
  - Raise msg_ready for one cycle: msg becomes the price-103 frame with msg_valid still 1, and byte_ready returns to 1.
- Timeout: send 10 valid bytes, then idle for TIMEOUT cycles.
  - frame_err pulses and drop_count increments.
  - A following complete frame is received intact.
  - A repeat run with a byte arriving at idle cycle TIMEOUT-1 produces no error.
- Reset mid-frame: drive rst=0 asynchronously (between clock edges) after 15 bytes.
  - All outputs return to their reset values immediately.
  - After release, a full 21-byte frame is assembled correctly.
- Saturation: force 260 header mismatches → drop_count=255 and holds at 255.
